expr_result_unpacker: RTL and testbench



---
 rtl/expr_result_unpacker.sv | 105 ++++++++++
 tb/tb_expr_result_unpacker.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/expr_result_unpacker.sv
// Unpacks a 90-bit word of 18 fields (y0 in MSBs) into 8-bit extended beats, one per handshake.
// Optional checksum port set enabled by defining EXPR_UNPACK_CHK_EN.
module expr_result_unpacker (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [89:0] in_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic [4:0]  out_idx,
  output logic        out_last
`ifdef EXPR_UNPACK_CHK_EN
  ,
  output logic        chk_valid,
  output logic [7:0]  chk_sum
`endif
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state;
  logic [89:0] shadow;
  logic [7:0]  fields [18];
  logic [4:0]  next_idx;
  logic [7:0]  next_field;

  // Groups of three fields (4,5,6 bits) repeat every 15 bits; odd groups are signed.
  for (genvar k = 0; k < 18; k++) begin : g_field
    localparam int G   = k / 3;
    localparam int R   = k % 3;
    localparam int W   = 4 + R;
    localparam int OFF = (R == 0) ? 0 : ((R == 1) ? 4 : 9);
    localparam int MSB = 89 - 15 * G - OFF;
    if (G % 2 == 1) begin : g_signed
      assign fields[k] = {{(8 - W){shadow[MSB]}}, shadow[MSB -: W]};
    end else begin : g_unsigned
      assign fields[k] = {{(8 - W){1'b0}}, shadow[MSB -: W]};
    end
  end

  assign next_idx  = out_idx + 5'd1;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == SEND);

  always_comb begin
    next_field = 8'h00;
    for (int k = 0; k < 18; k++) begin
      if (next_idx == 5'(k)) next_field = fields[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      shadow   <= '0;
      out_data <= 8'h00;
      out_idx  <= 5'd0;
      out_last <= 1'b0;
`ifdef EXPR_UNPACK_CHK_EN
      chk_valid <= 1'b0;
      chk_sum   <= 8'h00;
`endif
    end else begin
`ifdef EXPR_UNPACK_CHK_EN
      chk_valid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (in_valid) begin
            shadow   <= in_y;
            out_idx  <= 5'd0;
            out_last <= 1'b0;
            // Field 0 is unsigned, so it can be loaded straight from the input.
            out_data <= {4'b0000, in_y[89:86]};
            state    <= SEND;
`ifdef EXPR_UNPACK_CHK_EN
            chk_sum  <= 8'h00;
`endif
          end
        end
        SEND: begin
          if (out_ready) begin
`ifdef EXPR_UNPACK_CHK_EN
            chk_sum <= chk_sum + out_data;
`endif
            if (out_last) begin
              state <= IDLE;
`ifdef EXPR_UNPACK_CHK_EN
              chk_valid <= 1'b1;
`endif
            end else begin
              out_idx  <= next_idx;
              out_data <= next_field;
              out_last <= (next_idx == 5'd17);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_expr_result_unpacker.sv
// Directed self-checking bench for expr_result_unpacker.
module tb_expr_result_unpacker;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [89:0] in_y;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [4:0]  out_idx;
  logic        out_last;
`ifdef EXPR_UNPACK_CHK_EN
  logic        chk_valid;
  logic [7:0]  chk_sum;
`endif

  int passes = 0;
  int checks = 0;
  logic [7:0] exp_f [18];

  expr_result_unpacker dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
`ifdef EXPR_UNPACK_CHK_EN
    ,
    .chk_valid (chk_valid),
    .chk_sum   (chk_sum)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
    checks++;
    assert (obs === e) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
  endtask

  // Walks the field widths from the top of the word.
  function automatic logic [7:0] model(input logic [89:0] w, input int k);
    int pos;
    int wd;
    logic [7:0] v;
    pos = 90;
    for (int j = 0; j < k; j++) pos -= 4 + (j % 3);
    wd = 4 + (k % 3);
    v = 8'h00;
    for (int b = 0; b < 8; b++) begin
      if (b < wd) v[b] = w[pos - wd + b];
      else        v[b] = ((k / 3) % 2 == 1) ? w[pos - 1] : 1'b0;
    end
    return v;
  endfunction

  task automatic load_model(input logic [89:0] w);
    for (int k = 0; k < 18; k++) exp_f[k] = model(w, k);
  endtask

  // mode 0: always ready; 1: ready pattern 1,0,0,1; 2: pattern plus input churn during SEND
  task automatic stream(input logic [89:0] w, input int mode, input string tag);
    int   expi;
    int   beats;
    int   cyc;
    logic rdy;
    logic [7:0] sum;
    chk({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_y     = w;
    @(negedge clk);
    in_valid = 1'b0;
    expi = 0; beats = 0; cyc = 0; sum = 8'h00;
    while (beats < 18 && cyc < 200) begin
      chk({tag, "_vld"},  32'(out_valid), 32'd1);
      chk({tag, "_rdy0"}, 32'(in_ready),  32'd0);
      chk({tag, "_idx"},  32'(out_idx),   32'(expi));
      chk({tag, "_dat"},  32'(out_data),  32'(exp_f[expi]));
      chk({tag, "_last"}, 32'(out_last),  32'(expi == 17));
      rdy = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      out_ready = rdy;
      if (mode == 2) begin
        in_valid = 1'b1;
        in_y     = ~w;
      end
      @(negedge clk);
      if (rdy) begin
        sum = sum + exp_f[expi];
        beats++;
        if (expi < 17) expi++;
      end
      cyc++;
    end
    chk({tag, "_beats"}, 32'(beats), 32'd18);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk({tag, "_end_vld"}, 32'(out_valid), 32'd0);
    chk({tag, "_end_rdy"}, 32'(in_ready),  32'd1);
`ifdef EXPR_UNPACK_CHK_EN
    chk({tag, "_chk_vld"}, 32'(chk_valid), 32'd1);
    chk({tag, "_chk_sum"}, 32'(chk_sum),   32'(sum));
`endif
  endtask

  logic [89:0] w;
  int          cyc;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_y      = '1;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_idx",   32'(out_idx),   32'd0);
    chk("rst_out_last",  32'(out_last),  32'd0);
`ifdef EXPR_UNPACK_CHK_EN
    chk("rst_chk_valid", 32'(chk_valid), 32'd0);
    chk("rst_chk_sum",   32'(chk_sum),   32'd0);
`endif
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_no_capture", 32'(out_valid), 32'd0);

    // All ones: unsigned groups give 0F,1F,3F; signed groups give FF. Sum is 0x3E.
    for (int g = 0; g < 6; g++) begin
      exp_f[3*g]   = (g % 2 == 1) ? 8'hFF : 8'h0F;
      exp_f[3*g+1] = (g % 2 == 1) ? 8'hFF : 8'h1F;
      exp_f[3*g+2] = (g % 2 == 1) ? 8'hFF : 8'h3F;
    end
    stream('1, 0, "ones");
`ifdef EXPR_UNPACK_CHK_EN
    chk("ones_sum_const", 32'(chk_sum), 32'h3E);
    @(negedge clk);
    chk("ones_chk_pulse_once", 32'(chk_valid), 32'd0);
    chk("ones_chk_sum_held",   32'(chk_sum),   32'h3E);
`endif

    // Only field MSBs set: unsigned 08,10,20; signed F8,F0,E0.
    w = '0;
    for (int g = 0; g < 6; g++) begin
      w[89 - 15*g] = 1'b1;
      w[85 - 15*g] = 1'b1;
      w[80 - 15*g] = 1'b1;
      exp_f[3*g]   = (g % 2 == 1) ? 8'hF8 : 8'h08;
      exp_f[3*g+1] = (g % 2 == 1) ? 8'hF0 : 8'h10;
      exp_f[3*g+2] = (g % 2 == 1) ? 8'hE0 : 8'h20;
    end
    stream(w, 0, "sign");

    w = 90'h3_A5F0_C39B_176E_48D1_A2C5;
    load_model(w);
    stream(w, 1, "bp");

    w = 90'h1_5C3E_9072_ADB4_6F18_3E97;
    load_model(w);
    stream(w, 2, "ign");

    // Reset mid-stream at idx 7.
    w = 90'h2_F00F_1234_5678_9ABC_DEF0;
    in_valid = 1'b1;
    in_y     = w;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (out_idx != 5'd7 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_reach_idx7", 32'(out_idx), 32'd7);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_in_ready",  32'(in_ready),  32'd1);
    chk("mid_out_idx",   32'(out_idx),   32'd0);
`ifdef EXPR_UNPACK_CHK_EN
    chk("mid_chk_valid", 32'(chk_valid), 32'd0);
`endif
    reset     = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
`ifdef EXPR_UNPACK_CHK_EN
    chk("mid_no_pulse_after", 32'(chk_valid), 32'd0);
`endif
    w = 90'h0_0123_4567_89AB_CDEF_FEDC;
    load_model(w);
    stream(w, 0, "after_rst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
